// File: rtl/tile_pkg.sv
// Shared constants and types for the tile fill engine: map geometry defaults,
// agent register map, CTRL bit positions and the engine state encoding.
package tile_pkg;

  localparam int COL_BITS_DEF = 7;
  localparam int ROW_BITS_DEF = 6;

  localparam logic [2:0] REG_X0   = 3'd0;
  localparam logic [2:0] REG_Y0   = 3'd1;
  localparam logic [2:0] REG_W    = 3'd2;
  localparam logic [2:0] REG_H    = 3'd3;
  localparam logic [2:0] REG_TILE = 3'd4;
  localparam logic [2:0] REG_CTRL = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_INCR  = 1;
  localparam int CTRL_IEN   = 2;
  localparam int CTRL_CLEAR = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/tile_rect_walker.sv
// Row-major rectangle scanner: produces the current tilemap column/row and a
// last-beat flag, stepping once per accepted host write.
module tile_rect_walker
  import tile_pkg::*;
#(
  parameter int COL_BITS = COL_BITS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                accept,
  input  logic [COL_BITS-1:0] x0,
  input  logic [ROW_BITS-1:0] y0,
  input  logic [7:0]          w,
  input  logic [7:0]          h,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                last
);

  logic [COL_BITS-1:0] x0_work;
  logic [7:0]          w_work;
  logic [7:0]          h_work;
  logic [7:0]          i_cnt;
  logic [7:0]          j_cnt;
  logic                row_end;

  assign row_end = (i_cnt == w_work - 8'd1);
  assign last    = row_end && (j_cnt == h_work - 8'd1);

  // col/row wrap for free at their natural widths, matching the map size
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_work <= '0;
      w_work  <= '0;
      h_work  <= '0;
      i_cnt   <= '0;
      j_cnt   <= '0;
      col     <= '0;
      row     <= '0;
    end else if (load) begin
      x0_work <= x0;
      w_work  <= w;
      h_work  <= h;
      i_cnt   <= '0;
      j_cnt   <= '0;
      col     <= x0;
      row     <= y0;
    end else if (accept) begin
      if (row_end) begin
        i_cnt <= '0;
        j_cnt <= j_cnt + 8'd1;
        col   <= x0_work;
        row   <= row + ROW_BITS'(1);
      end else begin
        i_cnt <= i_cnt + 8'd1;
        col   <= col + COL_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/tile_fill_engine.sv
// Rectangle-fill bridge: CPU-programmed registers on the agent side, one
// tilemap byte write per cycle on the host side toward the tile display.
module tile_fill_engine
  import tile_pkg::*;
#(
  parameter int COL_BITS = COL_BITS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        irq,
  output logic        m_chipselect,
  output logic        m_write,
  output logic [14:0] m_address,
  output logic [7:0]  m_writedata,
  input  logic        m_waitrequest
);

  state_t state, state_next;

  logic [COL_BITS-1:0] x0_reg;
  logic [ROW_BITS-1:0] y0_reg;
  logic [7:0]          w_reg;
  logic [7:0]          h_reg;
  logic [7:0]          tile_reg;
  logic                incr_reg;
  logic                ien_reg;
  logic                done;
  logic                zero_pend;
  logic                incr_work;
  logic [7:0]          data_work;

  logic                reg_wr;
  logic                ctrl_wr;
  logic                start_req;
  logic                go;
  logic                accept;
  logic                finish;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;
  logic                last;

  assign reg_wr    = chipselect && write;
  assign ctrl_wr   = reg_wr && (address == REG_CTRL);
  assign start_req = ctrl_wr && writedata[CTRL_START] && (state == IDLE);
  assign accept    = (state == RUN) && !m_waitrequest;
  assign finish    = accept && last;

  tile_rect_walker #(
    .COL_BITS (COL_BITS),
    .ROW_BITS (ROW_BITS)
  ) u_walker (
    .clk    (clk),
    .reset  (reset),
    .load   (go),
    .accept (accept),
    .x0     (x0_reg),
    .y0     (y0_reg),
    .w      (w_reg),
    .h      (h_reg),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    go         = 1'b0;
    case (state)
      IDLE: begin
        if (start_req && (w_reg != 8'd0) && (h_reg != 8'd0)) begin
          go         = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // completion outranks any clear landing on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_reg    <= '0;
      y0_reg    <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      tile_reg  <= '0;
      incr_reg  <= 1'b0;
      ien_reg   <= 1'b0;
      done      <= 1'b0;
      zero_pend <= 1'b0;
      incr_work <= 1'b0;
      data_work <= '0;
    end else begin
      if (reg_wr) begin
        case (address)
          REG_X0:   x0_reg   <= writedata[COL_BITS-1:0];
          REG_Y0:   y0_reg   <= writedata[ROW_BITS-1:0];
          REG_W:    w_reg    <= writedata;
          REG_H:    h_reg    <= writedata;
          REG_TILE: tile_reg <= writedata;
          REG_CTRL: begin
            incr_reg <= writedata[CTRL_INCR];
            ien_reg  <= writedata[CTRL_IEN];
          end
          default: ;
        endcase
      end

      zero_pend <= start_req && !go;

      if (finish || zero_pend)                    done <= 1'b1;
      else if (start_req)                         done <= 1'b0;
      else if (ctrl_wr && writedata[CTRL_CLEAR])  done <= 1'b0;

      if (go) begin
        incr_work <= writedata[CTRL_INCR];
        data_work <= tile_reg;
      end else if (accept && incr_work) begin
        data_work <= data_work + 8'd1;
      end
    end
  end

  assign m_chipselect = (state == RUN);
  assign m_write      = (state == RUN);
  assign m_address    = {2'b00, row, col};
  assign m_writedata  = data_work;
  assign irq          = done && ien_reg;

  always_comb begin
    readdata = 8'h00;
    case (address)
      REG_X0:   readdata = 8'(x0_reg);
      REG_Y0:   readdata = 8'(y0_reg);
      REG_W:    readdata = w_reg;
      REG_H:    readdata = h_reg;
      REG_TILE: readdata = tile_reg;
      REG_CTRL: readdata = {(state == RUN), 4'b0000, ien_reg, incr_reg, done};
      default:  readdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tile_fill_engine.sv
// Directed bench for tile_fill_engine: register programming, fill scans with
// wrap, incrementing data, stalls, zero-size starts, ignored starts and reset.
module tb_tile_fill_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [2:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        irq;
  logic        m_chipselect;
  logic        m_write;
  logic [14:0] m_address;
  logic [7:0]  m_writedata;
  logic        m_waitrequest;

  int checks = 0;
  int fails = 0;
  int accepted_cnt = 0;
  int active_cnt = 0;
  int acc_base;
  int act_base;

  tile_fill_engine dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_address     (m_address),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest)
  );

  always #5 clk = ~clk;

  // bus monitor: counts host-active cycles and accepted beats
  always @(posedge clk) begin
    if (!reset && m_write) active_cnt <= active_cnt + 1;
    if (!reset && m_write && !m_waitrequest) accepted_cnt <= accepted_cnt + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    chipselect = 1'b1;
    write      = 1'b0;
    address    = a;
    #1;
    check_output(tag, {24'd0, readdata}, {24'd0, exp});
    chipselect = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [14:0] a, input logic [7:0] d);
    check_output({tag, "_wr"}, {31'd0, m_write}, 32'd1);
    check_output({tag, "_addr"}, {17'd0, m_address}, {17'd0, a});
    check_output({tag, "_data"}, {24'd0, m_writedata}, {24'd0, d});
  endtask

  task automatic program_rect(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                              input logic [7:0] h, input logic [7:0] t);
    cpu_write(3'd0, x);
    cpu_write(3'd1, y);
    cpu_write(3'd2, w);
    cpu_write(3'd3, h);
    cpu_write(3'd4, t);
  endtask

  logic [14:0] wrap_addr [6];

  initial begin
    wrap_addr[0] = 15'h1FFE;
    wrap_addr[1] = 15'h1FFF;
    wrap_addr[2] = 15'h1F80;
    wrap_addr[3] = 15'h007E;
    wrap_addr[4] = 15'h007F;
    wrap_addr[5] = 15'h0000;

    reset = 1'b1;
    chipselect = 1'b0;
    write = 1'b0;
    address = 3'd0;
    writedata = 8'h00;
    m_waitrequest = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    $display("[TB] reset state");
    check_output("rst_m_write", {31'd0, m_write}, 32'd0);
    check_output("rst_m_cs", {31'd0, m_chipselect}, 32'd0);
    check_output("rst_m_addr", {17'd0, m_address}, 32'd0);
    check_output("rst_m_data", {24'd0, m_writedata}, 32'd0);
    check_output("rst_irq", {31'd0, irq}, 32'd0);
    read_check("rst_ctrl", 3'd5, 8'h00);
    read_check("rst_w", 3'd2, 8'h00);

    $display("[TB] wrapping fill, constant data");
    program_rect(8'd126, 8'd63, 8'd3, 8'd2, 8'h41);
    read_check("rd_x0", 3'd0, 8'd126);
    read_check("rd_y0", 3'd1, 8'd63);
    read_check("rd_reg6", 3'd6, 8'h00);
    act_base = active_cnt;
    cpu_write(3'd5, 8'h01);
    for (int k = 0; k < 6; k++) begin
      if (k != 0) step();
      check_beat($sformatf("t1_b%0d", k), wrap_addr[k], 8'h41);
    end
    read_check("t1_busy", 3'd5, 8'h80);
    step();
    check_output("t1_idle", {31'd0, m_write}, 32'd0);
    read_check("t1_ctrl", 3'd5, 8'h01);
    check_output("t1_active", active_cnt - act_base, 32'd6);

    $display("[TB] incrementing data");
    program_rect(8'd0, 8'd0, 8'd4, 8'd1, 8'hFE);
    cpu_write(3'd5, 8'h03);
    check_beat("t2_b0", 15'd0, 8'hFE);
    step();
    check_beat("t2_b1", 15'd1, 8'hFF);
    step();
    check_beat("t2_b2", 15'd2, 8'h00);
    step();
    check_beat("t2_b3", 15'd3, 8'h01);
    step();
    check_output("t2_idle", {31'd0, m_write}, 32'd0);
    read_check("t2_ctrl", 3'd5, 8'h03);

    $display("[TB] stalled beat");
    program_rect(8'd126, 8'd63, 8'd3, 8'd2, 8'h41);
    act_base = active_cnt;
    acc_base = accepted_cnt;
    cpu_write(3'd5, 8'h01);
    read_check("t3_done_clr", 3'd5, 8'h80);
    for (int k = 0; k < 6; k++) begin
      if (k != 0) step();
      check_beat($sformatf("t3_b%0d", k), wrap_addr[k], 8'h41);
      if (k == 2) begin
        m_waitrequest = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step();
          check_beat($sformatf("t3_stall%0d", s), wrap_addr[2], 8'h41);
        end
        m_waitrequest = 1'b0;
      end
    end
    step();
    check_output("t3_idle", {31'd0, m_write}, 32'd0);
    check_output("t3_active", active_cnt - act_base, 32'd9);
    check_output("t3_accepted", accepted_cnt - acc_base, 32'd6);
    read_check("t3_ctrl", 3'd5, 8'h01);

    $display("[TB] zero-width start");
    cpu_write(3'd2, 8'd0);
    acc_base = accepted_cnt;
    act_base = active_cnt;
    cpu_write(3'd5, 8'h05);
    step();
    step();
    check_output("t4_no_write", {31'd0, m_write}, 32'd0);
    check_output("t4_active", active_cnt - act_base, 32'd0);
    read_check("t4_ctrl", 3'd5, 8'h05);
    check_output("t4_irq", {31'd0, irq}, 32'd1);
    cpu_write(3'd5, 8'h80);
    check_output("t4_irq_clr", {31'd0, irq}, 32'd0);
    read_check("t4_ctrl_clr", 3'd5, 8'h00);

    $display("[TB] start while busy");
    program_rect(8'd10, 8'd2, 8'd3, 8'd1, 8'h22);
    cpu_write(3'd5, 8'h01);
    check_beat("t5_b0", 15'h010A, 8'h22);
    cpu_write(3'd0, 8'd50);
    check_beat("t5_b1", 15'h010B, 8'h22);
    cpu_write(3'd5, 8'h01);
    check_beat("t5_b2", 15'h010C, 8'h22);
    step();
    check_output("t5_idle", {31'd0, m_write}, 32'd0);
    cpu_write(3'd5, 8'h01);
    check_beat("t5_n0", 15'h0132, 8'h22);
    step();
    check_beat("t5_n1", 15'h0133, 8'h22);
    step();
    check_beat("t5_n2", 15'h0134, 8'h22);
    step();
    check_output("t5_n_idle", {31'd0, m_write}, 32'd0);

    $display("[TB] reset mid-run");
    program_rect(8'd126, 8'd63, 8'd3, 8'd2, 8'h41);
    acc_base = accepted_cnt;
    cpu_write(3'd5, 8'h01);
    step();
    step();
    check_beat("t6_b2", 15'h1F80, 8'h41);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_output("t6_m_write", {31'd0, m_write}, 32'd0);
    check_output("t6_m_cs", {31'd0, m_chipselect}, 32'd0);
    read_check("t6_ctrl", 3'd5, 8'h00);
    repeat (5) step();
    check_output("t6_accepted", accepted_cnt - acc_base, 32'd2);
    check_output("t6_still_idle", {31'd0, m_write}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
